rp_subtractor_seq: RTL and testbench

Multi-cycle ripple-borrow subtractor: the subtraction counterpart to the team's combinational ripple-carry adder. It accepts an operand pair over a valid/ready handshake and computes `a - b - bin` one CHUNK-bit slice per clock, carrying the borrow in a register between slices. It then presents the difference, borrow-out and signed-overflow flag on a valid/ready output port. It sits in datapaths where a full-width combinational borrow chain would not close timing in one cycle.

---
 rtl/rp_subtractor_seq_if.sv | 26 ++
 rtl/rp_subtractor_seq.sv | 112 +++++++++++
 tb/tb_rp_subtractor_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rp_subtractor_seq_if.sv
// Operand/result handshake bundle for the sequential ripple-borrow subtractor.
// The slave side is the subtractor; the master side drives operands and consumes results.
interface rp_subtractor_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/rp_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor: computes a - b - bin one CHUNK-bit slice per
// clock, keeping the inter-slice carry in a register, and presents the result on a handshake.
module rp_subtractor_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  rp_subtractor_seq_if.slave bus
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [CntW-1:0] LastSlice = CntW'(NChunk - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   k_q, k_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       base;
  logic [CHUNK-1:0]  sl_a;
  logic [CHUNK-1:0]  sl_b;
  logic [CHUNK:0]    sum;
  logic [WIDTH-1:0]  slice_mask;

  // Subtraction as a + ~b + carry, where carry = ~borrow.
  always_comb begin
    base       = 32'(k_q) * CHUNK;
    sl_a       = CHUNK'(a_q >> base);
    sl_b       = CHUNK'(b_q >> base);
    sum        = {1'b0, sl_a} + {1'b0, ~sl_b} + {{CHUNK{1'b0}}, carry_q};
    slice_mask = WIDTH'({CHUNK{1'b1}}) << base;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = ~bus.bin;
          k_d     = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        diff_d  = (diff_q & ~slice_mask) | (WIDTH'(sum[CHUNK-1:0]) << base);
        carry_d = sum[CHUNK];
        if (k_q == LastSlice) begin
          bout_d  = ~sum[CHUNK];
          // Top bit of the final slice is the result sign bit.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rp_subtractor_seq.sv
// Self-checking bench for rp_subtractor_seq: directed cases plus a randomized sweep
// compared against a wide-integer reference of a - b - bin.
module tb_rp_subtractor_seq;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  rp_subtractor_seq_if #(.WIDTH(WIDTH)) bus ();

  rp_subtractor_seq #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide-integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic bin,
                                output logic [31:0] diff, output logic bout, output logic ovf);
    longint ua, ub, sa, sb, ur, sr;
    ua   = longint'({32'b0, a});
    ub   = longint'({32'b0, b});
    sa   = longint'(signed'(a));
    sb   = longint'(signed'(b));
    ur   = ua - ub - longint'(bin);
    sr   = sa - sb - longint'(bin);
    diff = ur[31:0];
    bout = (ur < 0);
    ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, check latency and result, then drain with a given stall.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input int stall, input string tag);
    logic [31:0] ediff;
    logic        ebout, eovf;
    int          cyc;
    model(a, b, bin, ediff, ebout, eovf);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.bin      = 1'($urandom);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(NCHUNK));
    check({tag, ".diff"}, 64'(bus.diff), 64'(ediff));
    check({tag, ".bout"}, 64'(bus.bout), 64'(ebout));
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(eovf));
    bus.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) step();
    if (stall > 0) check({tag, ".held"}, 64'({bus.out_valid, bus.diff}), 64'({1'b1, ediff}));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ".drained"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
  endtask

  initial begin
    logic [31:0] ediff, na, nb, held_diff;
    logic        ebout, eovf, held_bout, held_ovf;
    int          cyc;
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset", 64'({bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf}),
          64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));

    // Directed cases
    run_op(32'd5, 32'd3, 1'b0, 0, "basic");
    check("basic.abs", 64'(bus.diff), 64'h2);
    run_op(32'd0, 32'd1, 1'b0, 0, "underflow1");
    check("underflow1.abs", 64'({bus.bout, bus.diff}), 64'({1'b1, 32'hFFFF_FFFF}));
    run_op(32'd0, 32'd0, 1'b1, 0, "underflow2");
    run_op(32'h0100_0000, 32'h1, 1'b0, 0, "ripple1");
    check("ripple1.abs", 64'({bus.bout, bus.diff}), 64'({1'b0, 32'h00FF_FFFF}));
    run_op(32'h0, 32'hFFFF_FFFF, 1'b1, 0, "ripple2");
    check("ripple2.abs", 64'({bus.bout, bus.diff}), 64'({1'b1, 32'h0}));
    run_op(32'h8000_0000, 32'h1, 1'b0, 0, "ovf1");
    check("ovf1.abs", 64'({bus.ovf, bus.bout, bus.diff}), 64'({1'b1, 1'b0, 32'h7FFF_FFFF}));
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ovf2");
    check("ovf2.abs", 64'({bus.ovf, bus.bout, bus.diff}), 64'({1'b1, 1'b1, 32'h8000_0000}));

    // Backpressure with new operands offered while DONE
    bus.a = 32'h1234_5678; bus.b = 32'h0000_1111; bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check("bp.latency", 64'(cyc), 64'(NCHUNK));
    check("bp.diff", 64'(bus.diff), 64'h1234_4567);
    held_diff = bus.diff;
    held_bout = bus.bout;
    held_ovf  = bus.ovf;
    na = 32'h0000_0010;
    nb = 32'h0000_0020;
    for (int i = 0; i < 10; i++) begin
      bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom);
      bus.in_valid = 1'b1;
      step();
      check("bp.hold", 64'({bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf}),
            64'({1'b0, 1'b1, held_diff, held_bout, held_ovf}));
    end
    bus.a = na; bus.b = nb; bus.bin = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp.release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    step();
    bus.in_valid = 1'b0;
    model(na, nb, 1'b1, ediff, ebout, eovf);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      step();
      cyc++;
    end
    check("bp.next.latency", 64'(cyc), 64'(NCHUNK));
    check("bp.next.result", 64'({bus.ovf, bus.bout, bus.diff}), 64'({eovf, ebout, ediff}));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Reset during the second BUSY cycle
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0BAD_F00D; bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", 64'({bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.ovf}),
          64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst_busy.no_stale", 64'(bus.out_valid), 64'b0);
    end

    // Randomized sweep with occasional output stalls
    for (int n = 0; n < 10000; n++) begin
      int stall;
      stall = (($urandom & 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op($urandom, $urandom, 1'($urandom), stall, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
